// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder that runs a 2-bit adder slice once per clock, least-significant digit first.
// Results (sum/cout/ovf) are updated only on the completing edge, together with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    // state is kept as a named register so checkers can bind to it directly
    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             c_mid;
    logic             c_out;
    logic [1:0]       slice_sum;
    logic [WIDTH+1:0] res_wide;

    // 2-bit adder slice; c_mid is the carry between its bit 0 and bit 1
    always_comb begin
        slice_sum[0] = op_a[0] ^ op_b[0] ^ carry;
        c_mid        = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
        slice_sum[1] = op_a[1] ^ op_b[1] ^ c_mid;
        c_out        = (op_a[1] & op_b[1]) | (c_mid & (op_a[1] ^ op_b[1]));
    end

    assign last     = (cnt == CW'(N - 1));
    assign res_wide = {slice_sum, res};
    assign busy     = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // New digits enter the result register from the top, so after N steps it holds the full sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_a  <= a;
                op_b  <= b;
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> 2;
                op_b  <= op_b >> 2;
                res   <= res_wide[WIDTH+1:2];
                carry <= c_out;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum  <= res_wide[WIDTH+1:2];
                    cout <= c_out;
                    ovf  <= c_mid ^ c_out;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule
